lifo_frame_reverser: RTL and testbench

LIFO_FRAME_REVERSER -- requirements
Module: lifo_frame_reverser

---
 rtl/lifo_reverser_pkg.sv | 9 +
 rtl/lifo_mem.sv | 26 ++
 rtl/lifo_frame_reverser.sv | 114 +++++++++++
 tb/tb_lifo_frame_reverser.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_reverser_pkg.sv
// Shared types for the LIFO frame reverser: the two-state control FSM encoding.
package lifo_reverser_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/lifo_mem.sv
// Beat storage for the frame reverser: synchronous write, asynchronous read, no reset.
module lifo_mem #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic [ADDRESS_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]    o_rd_data
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lifo_frame_reverser.sv
// Stores one inbound frame and replays it last-beat-first. Optional sticky overflow
// flag port ovf_err is enabled by defining LIFO_REVERSER_OVF_ERR_EN.
module lifo_frame_reverser
    import lifo_reverser_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
`ifdef LIFO_REVERSER_OVF_ERR_EN
    output logic                  ovf_err,
`endif
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]   PTR_FULL = DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0]   PTR_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    state_e                   r_state;
    logic [ADDRESS_WIDTH:0]   r_ptr;

    logic                     w_in_xfer;
    logic                     w_out_xfer;
    logic                     w_full;
    logic                     w_wr_en;
    logic [ADDRESS_WIDTH-1:0] w_rd_addr;
    logic [ADDRESS_WIDTH:0]   w_ptr_dec;
    logic [DATA_WIDTH-1:0]    w_rd_data;

    assign s_ready    = (r_state == FILL);
    assign m_valid    = (r_state == DRAIN);
    assign m_last     = (r_state == DRAIN) && (r_ptr == PTR_ONE);
    assign busy       = (r_state == DRAIN) || (r_ptr != '0);

    assign w_in_xfer  = s_valid && s_ready;
    assign w_out_xfer = m_valid && m_ready;
    assign w_full     = (r_ptr == PTR_FULL);
    assign w_wr_en    = w_in_xfer && !w_full;
    assign w_ptr_dec  = r_ptr - PTR_ONE;
    // Low-bit subtract wraps DEPTH to DEPTH-1, so the top ptr bit is never needed here.
    assign w_rd_addr  = r_ptr[ADDRESS_WIDTH-1:0] - ADDR_ONE;
    assign m_data     = w_rd_data;

    lifo_mem #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_ptr[ADDRESS_WIDTH-1:0]),
        .i_wr_data (s_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_wr_en) begin
                        r_ptr <= r_ptr + PTR_ONE;
                    end
                    // A discarded last beat still closes the frame.
                    if (w_in_xfer && s_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_out_xfer) begin
                        if (m_last) begin
                            r_state <= FILL;
                            r_ptr   <= '0;
                        end else begin
                            r_ptr   <= w_ptr_dec;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

`ifdef LIFO_REVERSER_OVF_ERR_EN
    logic r_ovf_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_err <= 1'b0;
        end else if (w_in_xfer && w_full) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign ovf_err = r_ovf_err;
`endif

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Self-checking bench for lifo_frame_reverser against a queue-based reversal model.
module tb_lifo_frame_reverser;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          busy;
`ifdef LIFO_REVERSER_OVF_ERR_EN
    logic          ovf_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lifo_frame_reverser #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
`ifdef LIFO_REVERSER_OVF_ERR_EN
        .ovf_err (ovf_err),
`endif
        .busy    (busy)
    );

    // Reference: keep the first DEPTH beats of the frame, emit them reversed.
    function automatic void model_reverse(input logic [DW-1:0] din[$], output logic [DW-1:0] dout[$]);
        dout = {};
        for (int i = 0; i < din.size() && i < DEPTH; i++) dout.push_front(din[i]);
    endfunction

    // Drives one frame starting at the current negedge; ends at the negedge after the last transfer.
    task automatic push_frame(input logic [DW-1:0] q[$], input bit gaps);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom);
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = q[i];
            s_last  = (i == q.size() - 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // mode 0: m_ready=1; mode 1: pattern 1,0,0 repeating; mode 2: random.
    task automatic pull_frame(input int mode, input int budget, output logic [DW-1:0] got[$],
                              output int lastpos, output int unstable, output int cycles,
                              output bit timeout);
        logic [DW-1:0] hold_d;
        logic          hold_l;
        bit            stalled = 0;
        bit            done = 0;
        got = {};
        lastpos = -1;
        unstable = 0;
        cycles = 0;
        hold_d = '0;
        hold_l = 1'b0;
        while (!done && cycles < budget) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cycles % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            s_last  = 1'($urandom_range(0, 1));
            if (m_valid) begin
                if (stalled && (m_data !== hold_d || m_last !== hold_l)) unstable++;
                if (m_ready) begin
                    got.push_back(m_data);
                    if (m_last) begin
                        lastpos = got.size() - 1;
                        done = 1;
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_d  = m_data;
                    hold_l  = m_last;
                end
            end
            @(negedge clk);
            cycles++;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        timeout = !done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef LIFO_REVERSER_OVF_ERR_EN
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %b expected 0", ovf_err); end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] act;
        int lastpos, unstable, cycles;
        bit timeout;
        in_q = '{8'h11, 8'h22, 8'h33};
        model_reverse(in_q, exp_q);
        push_frame(in_q, 0);
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_m_valid: got %b expected 1", m_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_drain: got %b expected 1", busy); end
        pull_frame(0, 50, got, lastpos, unstable, cycles, timeout);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", timeout); end
        n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_len: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) act = got[i]; else act = 'x;
            n_checks++; if (act !== exp_q[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, act, exp_q[i]); end
        end
        n_checks++; if (lastpos !== 2) begin n_fail++; $display("FAIL basic_last_pos: got %0d expected 2", lastpos); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_turnaround: got %b expected 1", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_full_frame;
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] act;
        int lastpos, unstable, cycles;
        bit timeout;
        in_q = {};
        for (int i = 0; i < DEPTH; i++) in_q.push_back(DW'(i));
        model_reverse(in_q, exp_q);
        push_frame(in_q, 0);
        pull_frame(0, 100, got, lastpos, unstable, cycles, timeout);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %b expected 0", timeout); end
        n_checks++; if (cycles !== DEPTH) begin n_fail++; $display("FAIL full_back_to_back_cycles: got %0d expected %0d", cycles, DEPTH); end
        n_checks++; if (got.size() !== DEPTH) begin n_fail++; $display("FAIL full_len: got %0d expected %0d", got.size(), DEPTH); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) act = got[i]; else act = 'x;
            n_checks++; if (act !== exp_q[i]) begin n_fail++; $display("FAIL full_data[%0d]: got %h expected %h", i, act, exp_q[i]); end
        end
        n_checks++; if (lastpos !== DEPTH - 1) begin n_fail++; $display("FAIL full_last_pos: got %0d expected %0d", lastpos, DEPTH - 1); end
    endtask

    task automatic test_overflow;
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] act;
        int lastpos, unstable, cycles;
        bit timeout;
        in_q = {};
        for (int i = 0; i < DEPTH + 2; i++) in_q.push_back(DW'(i));
        model_reverse(in_q, exp_q);
        for (int i = 0; i < in_q.size(); i++) begin
            s_valid = 1'b1;
            s_data  = in_q[i];
            s_last  = (i == in_q.size() - 1);
            n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_s_ready[%0d]: got %b expected 1", i, s_ready); end
            if (i == 3) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_fill: got %b expected 1", busy); end
            end
`ifdef LIFO_REVERSER_OVF_ERR_EN
            n_checks++;
            if (ovf_err !== (i > DEPTH)) begin
                n_fail++; $display("FAIL ovf_err_beat[%0d]: got %b expected %b", i, ovf_err, (i > DEPTH));
            end
`endif
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_entry: got %b expected 1", m_valid); end
        pull_frame(0, 100, got, lastpos, unstable, cycles, timeout);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout: got %b expected 0", timeout); end
        n_checks++; if (got.size() !== DEPTH) begin n_fail++; $display("FAIL ovf_len: got %0d expected %0d", got.size(), DEPTH); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) act = got[i]; else act = 'x;
            n_checks++; if (act !== exp_q[i]) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, act, exp_q[i]); end
        end
`ifdef LIFO_REVERSER_OVF_ERR_EN
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %b expected 1", ovf_err); end
`endif
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] act;
        int lastpos, unstable, cycles;
        bit timeout;
        in_q = {};
        for (int i = 0; i < 4; i++) in_q.push_back(DW'($urandom));
        model_reverse(in_q, exp_q);
        push_frame(in_q, 0);
        pull_frame(1, 100, got, lastpos, unstable, cycles, timeout);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", timeout); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stall_stability: got %0d changes expected 0", unstable); end
        n_checks++; if (got.size() !== 4) begin n_fail++; $display("FAIL bp_len: got %0d expected 4", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) act = got[i]; else act = 'x;
            n_checks++; if (act !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, act, exp_q[i]); end
        end
        n_checks++; if (lastpos !== 3) begin n_fail++; $display("FAIL bp_last_pos: got %0d expected 3", lastpos); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] got[$];
        int lastpos, unstable, cycles;
        bit timeout;
        in_q = '{8'hA5};
        push_frame(in_q, 0);
        pull_frame(0, 20, got, lastpos, unstable, cycles, timeout);
        n_checks++; if (got.size() !== 1) begin n_fail++; $display("FAIL single_len: got %0d expected 1", got.size()); end
        n_checks++; if (got.size() > 0 && got[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", got[0]); end
        n_checks++; if (lastpos !== 0) begin n_fail++; $display("FAIL single_last: got %0d expected 0", lastpos); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL single_turnaround: got %b expected 1", s_ready); end
        in_q = '{8'h01, 8'h02};
        push_frame(in_q, 0);
        pull_frame(0, 20, got, lastpos, unstable, cycles, timeout);
        n_checks++; if (got.size() !== 2) begin n_fail++; $display("FAIL b2b_len: got %0d expected 2", got.size()); end
        n_checks++; if (got.size() > 0 && got[0] !== 8'h02) begin n_fail++; $display("FAIL b2b_data0: got %h expected 02", got[0]); end
        n_checks++; if (got.size() > 1 && got[1] !== 8'h01) begin n_fail++; $display("FAIL b2b_data1: got %h expected 01", got[1]); end
        n_checks++; if (lastpos !== 1) begin n_fail++; $display("FAIL b2b_last: got %0d expected 1", lastpos); end
    endtask

    task automatic test_reset_mid_drain;
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] got[$];
        int lastpos, unstable, cycles;
        bit timeout;
        in_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        push_frame(in_q, 0);
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        m_ready = 1'b0;
        n_checks++; if (m_data !== 8'h53) begin n_fail++; $display("FAIL rst_pre_data: got %h expected 53", m_data); end
        reset = 1'b1;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_m_valid: got %b expected 0", m_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_s_ready: got %b expected 1", s_ready); end
`ifdef LIFO_REVERSER_OVF_ERR_EN
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf_err: got %b expected 0", ovf_err); end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_q = '{8'h7E};
        push_frame(in_q, 0);
        pull_frame(0, 20, got, lastpos, unstable, cycles, timeout);
        n_checks++; if (got.size() !== 1) begin n_fail++; $display("FAIL rst_next_len: got %0d expected 1", got.size()); end
        n_checks++; if (got.size() > 0 && got[0] !== 8'h7E) begin n_fail++; $display("FAIL rst_next_data: got %h expected 7e", got[0]); end
        n_checks++; if (lastpos !== 0) begin n_fail++; $display("FAIL rst_next_last: got %0d expected 0", lastpos); end
    endtask

    task automatic test_random;
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got[$];
        logic [DW-1:0] act;
        int lastpos, unstable, cycles, n;
        bit timeout;
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, DEPTH + 4);
            in_q = {};
            for (int i = 0; i < n; i++) in_q.push_back(DW'($urandom));
            model_reverse(in_q, exp_q);
            push_frame(in_q, 1);
            pull_frame(2, 400, got, lastpos, unstable, cycles, timeout);
            n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b expected 0", f, timeout); end
            n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL rand%0d_stability: got %0d expected 0", f, unstable); end
            n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d expected %0d", f, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got.size()) act = got[i]; else act = 'x;
                n_checks++; if (act !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_data[%0d]: got %h expected %h", f, i, act, exp_q[i]); end
            end
            n_checks++; if (lastpos !== exp_q.size() - 1) begin n_fail++; $display("FAIL rand%0d_last: got %0d expected %0d", f, lastpos, exp_q.size() - 1); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_basic();
        test_full_frame();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
